// File: rtl/display_scan_driver.sv
// Time-multiplexed scan driver for an 8-digit common-anode 7-segment display.
// All eight input words are snapshotted once per frame so a frame never mixes old and new values.
module display_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  output logic [7:0] an,
  output logic [7:0] dec_ddp,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0][5:0]    frame_q, frame_d;
  logic [7:0]         an_q, an_d;
  logic [7:0]         dec_q, dec_d;
  logic               frame_start_q, frame_start_d;

  logic               tick;
  logic               snap;
  logic [5:0]         slot_word;
  logic [6:0]         seg;

  always_comb begin
    tick          = (cnt_q == LAST);
    snap          = tick && (idx_q == 3'd7);
    cnt_d         = tick ? '0 : cnt_q + CW'(1);
    idx_d         = tick ? idx_q + 3'd1 : idx_q;
    frame_d       = snap ? {d8, d7, d6, d5, d4, d3, d2, d1} : frame_q;
    frame_start_d = snap;
  end

  // Active-low abcdefg, full hex so values above 9 show as letters.
  always_comb begin
    slot_word = frame_q[idx_q];
    seg       = 7'b1111111;
    case (slot_word[4:1])
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

  // Outputs are registered from the current idx, so they trail idx by one clock.
  always_comb begin
    an_d  = 8'hFF;
    dec_d = 8'hFF;
    if (slot_word[5]) begin
      an_d  = ~(8'd1 << idx_q);
      dec_d = {seg, slot_word[0]};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= 3'd7;
      frame_q       <= '0;
      an_q          <= 8'hFF;
      dec_q         <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      frame_q       <= frame_d;
      an_q          <= an_d;
      dec_q         <= dec_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign dec_ddp     = dec_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver: a per-frame scoreboard is filled at each
// snapshot from the driven words and drained slot by slot as the display scans.
module tb_display_scan_driver;

  localparam int RD = 4;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [7:0][5:0] words = '0;
  logic [7:0]     an;
  logic [7:0]     dec_ddp;
  logic           frame_start;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [15:0] sb_q[$];
  logic [15:0] cur_exp = 16'hFFFF;
  logic        cur_valid = 1'b0;

  display_scan_driver #(.REFRESH_DIV(RD)) dut (
    .clock       (clock),
    .reset       (reset),
    .d1          (words[0]),
    .d2          (words[1]),
    .d3          (words[2]),
    .d4          (words[3]),
    .d5          (words[4]),
    .d6          (words[5]),
    .d7          (words[6]),
    .d8          (words[7]),
    .an          (an),
    .dec_ddp     (dec_ddp),
    .frame_start (frame_start)
  );

  initial forever #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int slot, input logic [5:0] word);
    words[slot] = word;
  endtask

  function automatic logic [6:0] segOf(input logic [3:0] v);
    logic [6:0] table_v [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return table_v[v];
  endfunction

  // Expected {an, dec_ddp} for one slot showing word w.
  function automatic logic [15:0] slotExpect(input logic [5:0] w, input int s);
    logic [7:0] a;
    if (!w[5]) return 16'hFFFF;
    a = ~(8'd1 << s);
    return {a, segOf(w[4:1]), w[0]};
  endfunction

  task automatic waitFrame();
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (frame_start) begin
        found = 1;
        break;
      end
    end
    if (!found) checkOutput("frame_timeout", 8'h00, 8'h01);
  endtask

  // Edges are numbered from the first rising edge after reset release.
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) edge_cnt = 0;
    else edge_cnt++;
  end

  initial forever begin
    int e;
    logic [7:0] exp_an, exp_dec;
    logic exp_fs;
    @(negedge clock);
    if (reset) begin
      sb_q.delete();
      cur_valid = 1'b0;
      checkOutput("reset_an", an, 8'hFF);
      checkOutput("reset_dec", dec_ddp, 8'hFF);
      checkOutput("reset_fs", {7'd0, frame_start}, 8'h00);
    end else begin
      e = edge_cnt;
      if (e >= RD + 1 && ((e - RD - 1) % RD) == 0) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_empty", 8'h00, 8'h01);
          cur_valid = 1'b0;
        end else begin
          cur_exp   = sb_q.pop_front();
          cur_valid = 1'b1;
        end
      end
      exp_an  = cur_valid ? cur_exp[15:8] : 8'hFF;
      exp_dec = cur_valid ? cur_exp[7:0]  : 8'hFF;
      exp_fs  = (e >= RD) && (((e - RD) % (8 * RD)) == 0);
      checkOutput("an", an, exp_an);
      checkOutput("dec", dec_ddp, exp_dec);
      checkOutput("frame_start", {7'd0, frame_start}, {7'd0, exp_fs});
      if ((e + 1) >= RD && (((e + 1 - RD) % (8 * RD)) == 0))
        for (int s = 0; s < 8; s++) sb_q.push_back(slotExpect(words[s], s));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic en_now;

    // Reset and first frame.
    for (int i = 0; i < 8; i++) applyStimulus(i, 6'b1_1000_1);
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    checkOutput("first_fs", {7'd0, frame_start}, 8'h01);
    checkOutput("first_an_dark", an, 8'hFF);
    @(posedge clock);
    #2;
    checkOutput("first_an", an, 8'hFE);
    checkOutput("first_dec", dec_ddp, 8'h01);
    repeat (30) @(posedge clock);

    // Scan order with values 1..8.
    #1;
    for (int i = 0; i < 8; i++) applyStimulus(i, {1'b1, 4'(i + 1), 1'b1});
    repeat (100) @(posedge clock);

    // Blank slot 5 and decimal point on slot 2.
    #3;
    applyStimulus(5, 6'b0_0000_1);
    applyStimulus(2, 6'b1_0101_0);
    waitFrame();
    repeat (9) @(posedge clock);
    #2;
    checkOutput("dp_an", an, 8'b1111_1011);
    checkOutput("dp_dec", dec_ddp, 8'b0100_1000);
    repeat (12) @(posedge clock);
    #2;
    checkOutput("blank_an", an, 8'hFF);
    checkOutput("blank_dec", dec_ddp, 8'hFF);

    // Hex digit changed mid-frame during slot 4.
    waitFrame();
    repeat (17) @(posedge clock);
    #3;
    applyStimulus(0, 6'b1_1111_1);
    repeat (16) @(posedge clock);
    #2;
    checkOutput("hex_an", an, 8'hFE);
    checkOutput("hex_dec", dec_ddp, 8'b0111_0001);

    // Asynchronous reset during slot 6.
    waitFrame();
    repeat (25) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_an", an, 8'hFF);
    checkOutput("async_dec", dec_ddp, 8'hFF);
    checkOutput("async_fs", {7'd0, frame_start}, 8'h00);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    checkOutput("rerun_fs", {7'd0, frame_start}, 8'h01);
    @(posedge clock);
    #2;
    checkOutput("rerun_dec", dec_ddp, 8'b0111_0001);

    // Enable toggle on d8 every frame.
    #1;
    for (int i = 0; i < 8; i++) applyStimulus(i, {1'b1, 4'(i + 1), 1'b1});
    for (int f = 0; f < 4; f++) begin
      waitFrame();
      en_now = words[7][5];
      repeat (29) @(posedge clock);
      #2;
      checkOutput("toggle_an", an, en_now ? 8'h7F : 8'hFF);
      applyStimulus(7, {~words[7][5], words[7][4:0]});
    end

    repeat (4) @(posedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
